// File: rtl/itcm_arb_pkg.sv
// itcm_arb_pkg: shared constants and types for the ITCM arbiter.
//   ITCM_ADDR_W / ITCM_DATA_W / ITCM_BE_W : geometry of the 16K x 32 itcm
//   PORT_FETCH / PORT_LOAD                : port indices (core fetch, debug/loader)
//   rsp_tag_t                             : response tag captured on grant
package itcm_arb_pkg;
  localparam int ITCM_ADDR_W = 14;
  localparam int ITCM_DATA_W = 32;
  localparam int ITCM_BE_W   = 4;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LOAD  = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
    logic is_read;
  } rsp_tag_t;
endpackage

// File: rtl/itcm_arb_grant.sv
// itcm_arb_grant: decides which requester owns the ITCM this cycle.
//   clk, rst   : clock, async active-high reset
//   req_valid  : [PORT_LOAD:PORT_FETCH] request valids
//   req_ready  : per-port ready (combinational from valids + state)
//   grant      : one-hot grant (valid & ready)
// Build option ITCM_ARB_RR_EN: round-robin with a 1-bit last-grant pointer.
// Default: fixed priority to fetch, with a starvation counter that forces
// one loader grant after STARVE_MAX consecutive refusals.
module itcm_arb_grant
  import itcm_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  output logic [1:0] grant
);

  assign grant = req_valid & req_ready;

`ifdef ITCM_ARB_RR_EN
  logic last;  // port granted most recently; reset to loader so fetch goes first

  always_comb begin
    req_ready = '0;
    if (!rst) begin
      req_ready[PORT_FETCH] = !req_valid[PORT_LOAD]  || (last == PORT_LOAD);
      req_ready[PORT_LOAD]  = !req_valid[PORT_FETCH] || (last == PORT_FETCH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    last <= PORT_LOAD;
    else if (grant[PORT_LOAD])  last <= PORT_LOAD;
    else if (grant[PORT_FETCH]) last <= PORT_FETCH;
  end
`else
  logic [7:0] starve_cnt;
  logic       forced;

  // Counter saturates the cycle the loader has been refused STARVE_MAX times;
  // the following cycle belongs to the loader unconditionally.
  assign forced = (starve_cnt == 8'(STARVE_MAX));

  always_comb begin
    req_ready = '0;
    if (!rst) begin
      req_ready[PORT_FETCH] = !forced;
      req_ready[PORT_LOAD]  = !req_valid[PORT_FETCH] || forced;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else if (req_valid[PORT_LOAD] && !grant[PORT_LOAD])
      starve_cnt <= starve_cnt + 8'd1;
    else
      starve_cnt <= '0;
  end
`endif

endmodule

// File: rtl/itcm_arbiter.sv
// itcm_arbiter: shares the single-port itcm between core fetch (m0) and the
// debug/loader port (m1). One access per cycle; the response returns to its
// owner exactly one cycle after grant.
//   clk, rst          : clock, async active-high reset
//   mN_req_*          : request channel (valid/ready handshake), N = 0, 1
//   mN_rsp_valid/rdata: one-cycle response; rdata is 0 for writes
//   ram_*             : direct drive of / read data from the itcm
// Build option ITCM_ARB_RR_EN selects round-robin arbitration (see itcm_arb_grant).
module itcm_arbiter
  import itcm_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ITCM_ADDR_W,
  parameter int DATA_WIDTH = ITCM_DATA_W,
  parameter int BE_WIDTH   = ITCM_BE_W,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_we,
  input  logic [BE_WIDTH-1:0]   m0_be,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_we,
  input  logic [BE_WIDTH-1:0]   m1_be,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int STAGES = 1;

  logic [1:0]      req_ready;
  logic [1:0]      grant;
  logic [STAGES:0] vld_pipe;
  rsp_tag_t        tag_d, tag_q;
  logic            sel_we;
  logic            rsp_live;

  itcm_arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
    .clk       (clk),
    .rst       (rst),
    .req_valid ({m1_req_valid, m0_req_valid}),
    .req_ready (req_ready),
    .grant     (grant)
  );

  assign m0_req_ready = req_ready[PORT_FETCH];
  assign m1_req_ready = req_ready[PORT_LOAD];

  // RAM mux: loader only when it holds the grant; otherwise fetch address
  // is presented and write strobes stay low.
  assign sel_we         = grant[PORT_LOAD] ? m1_we : m0_we;
  assign ram_addr       = grant[PORT_LOAD] ? m1_addr  : m0_addr;
  assign ram_wr_data    = grant[PORT_LOAD] ? m1_wdata : m0_wdata;
  assign ram_wr_en      = (|grant) && sel_we && !rst;
  assign ram_wr_byte_en = !ram_wr_en       ? '0
                        : grant[PORT_LOAD] ? m1_be : m0_be;

  assign vld_pipe[0]   = |grant;
  assign tag_d.valid   = vld_pipe[0];
  assign tag_d.port    = grant[PORT_LOAD] ? PORT_LOAD : PORT_FETCH;
  assign tag_d.is_read = !sel_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_q <= '0;
    else     tag_q <= tag_d;
  end

  assign vld_pipe[STAGES] = tag_q.valid;

  // Gate with rst so a response in flight when reset arrives is never seen.
  assign rsp_live     = vld_pipe[STAGES] && !rst;
  assign m0_rsp_valid = rsp_live && (tag_q.port == PORT_FETCH);
  assign m1_rsp_valid = rsp_live && (tag_q.port == PORT_LOAD);
  assign m0_rdata     = (m0_rsp_valid && tag_q.is_read) ? ram_rd_data : '0;
  assign m1_rdata     = (m1_rsp_valid && tag_q.is_read) ? ram_rd_data : '0;

endmodule

// File: doc/itcm_arbiter.md
# itcm_arbiter

Two-requester arbiter sharing the single-port instruction TCM (`itcm`, 16K x 32, byte-write, 1-cycle read latency, no output register) between the core fetch port (m0) and the debug/loader port (m1). Accepts at most one request per cycle, drives the RAM address, write and byte-enable lines directly, and returns each response to its owner exactly one cycle after grant. Sits between the RISC-V core / UART loader and the `itcm` instance in the SoC top.

## Interface
- `ADDR_WIDTH`, 14, word address width; matches `itcm`.
- `DATA_WIDTH`, 32, data width.
- `BE_WIDTH`, 4, byte enables (DATA_WIDTH/8).
- `STARVE_MAX`, 8, max consecutive cycles m1 may be refused while valid (fixed-priority mode only); range 1..255.

- `clk` in 1: single clock for block and RAM.
- `rst` in 1: asynchronous, active-high reset.
- `mN_req_valid` in 1 (N = 0, 1): request present.
- `mN_req_ready` out 1: request accepted this cycle.
- `mN_addr` in ADDR_WIDTH: word address.
- `mN_we` in 1: 1 = write, 0 = read.
- `mN_be` in BE_WIDTH: byte enables (writes only).
- `mN_wdata` in DATA_WIDTH: write data.
- `mN_rsp_valid` out 1: response for this port's request.
- `mN_rdata` out DATA_WIDTH: read data; 0 for write responses.
- `ram_addr` out ADDR_WIDTH; `ram_wr_data` out DATA_WIDTH; `ram_wr_en` out 1; `ram_wr_byte_en` out BE_WIDTH: to `itcm`.
- `ram_rd_data` in DATA_WIDTH: from `itcm`.

## Operation
- Handshake: transfer when valid && ready in the same cycle. Once valid is raised, address/we/be/wdata must stay stable until accepted. Ready is combinational from valids and arbiter state; no valid-to-ready dependency from requesters.
- Default (fixed priority): m0 wins. `m0_req_ready` = 1 outside reset; `m1_req_ready` = !m0_req_valid || forced.
- Starvation counter (8 bit): increments each cycle m1 is valid and refused; when it reaches STARVE_MAX, the next cycle is forced to m1 (m0 ready = 0). Counter clears on any m1 grant or when m1 not valid.
- RAM mux: selects the granted port; no grant -> `ram_wr_en` = 0, `ram_wr_byte_en` = 0, `ram_addr` = m0_addr.
- `ram_wr_en` = granted we; `ram_wr_byte_en` = granted be on writes, all-zero on reads.
- Response register: on grant, store {valid, port, is_read}. Next cycle assert that port's `rsp_valid` for one cycle; `rdata` = `ram_rd_data` if read, else 0. Responses cannot be back-pressured.
- Reset values: all `*_ready`, `*_rsp_valid`, `ram_wr_en`, `ram_wr_byte_en` = 0; `rdata` = 0; counter = 0; RR pointer = m1 (m0 first).
- Reset mid-operation: a pending response is dropped; a write granted in the reset cycle is not issued (`ram_wr_en` gated by `rst`).

## Timing
- Grant in cycle T -> RAM sampled at end of T -> `rsp_valid` + data in T+1.
- Throughput one access per cycle; back-to-back grants to either port allowed.
- Read-after-write same address, consecutive cycles: read returns new data (NORMAL_WRITE RAM, separate cycles).
- Worst-case m1 wait in fixed mode: STARVE_MAX cycles, grant in cycle STARVE_MAX+1.

## Configuration
- `ITCM_ARB_RR_EN` defined: round-robin replaces fixed priority. 1-bit last-grant pointer; both valid -> grant port != pointer; single valid -> that port granted. Pointer updates on every grant. Starvation counter and STARVE_MAX unused.
- Undefined: fixed priority with starvation guard as above.

## Structure
- `itcm_arb_pkg`: ITCM_ADDR_W = 14, ITCM_DATA_W = 32, ITCM_BE_W = 4, port index constants PORT_FETCH = 0, PORT_LOAD = 1, and the response-tag struct {valid, port, is_read}.
- Sub-module `itcm_arb_grant`: valids in, one-hot grant out, owns starvation counter / RR pointer. Top holds the mux and response register.

## Test plan
- Single m0 read of addr 0x0010 preloaded 0xDEADBEEF -> m0_rsp_valid one cycle later, m0_rdata = 0xDEADBEEF, m1 outputs idle.
- m1 write addr 0x3FFF, be 4'b0011, wdata 0x12345678 over 0xFFFFFFFF, then read -> 0xFFFF5678.
- Both valid continuously, STARVE_MAX = 8 (fixed) -> m0 granted 8 cycles, m1 granted in cycle 9, pattern repeats; no response lost or duplicated.
- Same traffic with `ITCM_ARB_RR_EN` -> grants alternate m0, m1, m0, ...; first grant to m0 after reset.
- Assert `rst` the cycle after an m1 read grant -> m1_rsp_valid never asserts, all outputs 0 during reset, first request after release served normally.
